// File: rtl/prores_block_scan_ctrl_if.sv
// Block-in / coefficient-out bus for prores_block_scan_ctrl.
// Optional macro PRORES_INTERLACED_SCAN_EN adds the scan_sel select line.
interface prores_block_scan_ctrl_if #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned COEF_W = 20,
  parameter int unsigned RUN_W  = 6
);
  logic                      slice_start;
  logic                      blk_valid;
  logic                      blk_ready;
  logic [7:0][7:0][IN_W-1:0] BLK_DATA;
`ifdef PRORES_INTERLACED_SCAN_EN
  logic                      scan_sel;
`endif
  logic                      dc_valid;
  logic [COEF_W-1:0]         DC_DATA;
  logic                      ac_valid;
  logic [RUN_W-1:0]          AC_RUN;
  logic [COEF_W-1:0]         AC_LEVEL;
  logic                      blk_done;

  // Upstream quantizer / downstream coders side
  modport master (
    output slice_start, blk_valid, BLK_DATA,
`ifdef PRORES_INTERLACED_SCAN_EN
    output scan_sel,
`endif
    input  blk_ready, dc_valid, DC_DATA, ac_valid, AC_RUN, AC_LEVEL, blk_done
  );

  // Scan controller side
  modport slave (
    input  slice_start, blk_valid, BLK_DATA,
`ifdef PRORES_INTERLACED_SCAN_EN
    input  scan_sel,
`endif
    output blk_ready, dc_valid, DC_DATA, ac_valid, AC_RUN, AC_LEVEL, blk_done
  );
endinterface

// File: rtl/prores_block_scan_ctrl.sv
// ProRes 8x8 block scan controller: latches a quantized block, emits the
// predicted DC, then walks the 63 AC positions emitting (run, level) pairs.
// Optional macro PRORES_INTERLACED_SCAN_EN adds the interlaced scan table,
// selected per block by bus.scan_sel.
module prores_block_scan_ctrl #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned COEF_W = 20,
  parameter int unsigned RUN_W  = 6
) (
  input  logic clk,
  input  logic reset_n,
  prores_block_scan_ctrl_if.slave bus
);
  localparam int unsigned MAG_W = 19;
  localparam int unsigned IDX_W = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(63);
  localparam logic signed [IN_W-1:0] CLAMP_HI = IN_W'((1 << (MAG_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] CLAMP_LO = ~CLAMP_HI;

  // Raster position (row*8+col) visited at each scan index
  localparam logic [IDX_W-1:0] PROG_SCAN [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
`ifdef PRORES_INTERLACED_SCAN_EN
  localparam logic [IDX_W-1:0] ILACE_SCAN [64] = '{
    6'd0,  6'd8,  6'd1,  6'd9,  6'd16, 6'd24, 6'd17, 6'd25,
    6'd2,  6'd10, 6'd3,  6'd11, 6'd18, 6'd26, 6'd19, 6'd27,
    6'd32, 6'd40, 6'd33, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49,
    6'd42, 6'd35, 6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd59,
    6'd4,  6'd12, 6'd5,  6'd6,  6'd13, 6'd20, 6'd28, 6'd21,
    6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36, 6'd44, 6'd37,
    6'd30, 6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
  };
`endif

  typedef enum logic [1:0] {S_IDLE, S_DC, S_AC} state_t;

  // Saturate to the 19-bit signed range and sign-extend to COEF_W
  function automatic logic signed [COEF_W-1:0] clamp_coef(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] y;
    if (x > CLAMP_HI)      y = CLAMP_HI;
    else if (x < CLAMP_LO) y = CLAMP_LO;
    else                   y = x;
    return COEF_W'(y);
  endfunction

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [RUN_W-1:0]         run_q, run_d;
  logic signed [COEF_W-1:0] prev_dc_q, prev_dc_d;
  logic                     ss_q, ss_d;
`ifdef PRORES_INTERLACED_SCAN_EN
  logic                     sel_q, sel_d;
`endif
  logic                     blk_ready_q, blk_ready_d;
  logic                     dc_valid_q, dc_valid_d;
  logic signed [COEF_W-1:0] dc_data_q, dc_data_d;
  logic                     ac_valid_q, ac_valid_d;
  logic [RUN_W-1:0]         ac_run_q, ac_run_d;
  logic signed [COEF_W-1:0] ac_level_q, ac_level_d;
  logic                     blk_done_q, blk_done_d;
  logic                     load;

  logic signed [COEF_W-1:0] coef_q [8][8];
  logic [IDX_W-1:0]         scan_pos;
  logic signed [COEF_W-1:0] scan_coef;

  // Coefficient at the current scan index
  always_comb begin
`ifdef PRORES_INTERLACED_SCAN_EN
    scan_pos = sel_q ? ILACE_SCAN[idx_q] : PROG_SCAN[idx_q];
`else
    scan_pos = PROG_SCAN[idx_q];
`endif
    scan_coef = coef_q[scan_pos[5:3]][scan_pos[2:0]];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_d       = run_q;
    prev_dc_d   = prev_dc_q;
    ss_d        = ss_q;
`ifdef PRORES_INTERLACED_SCAN_EN
    sel_d       = sel_q;
`endif
    blk_ready_d = blk_ready_q;
    dc_valid_d  = 1'b0;
    dc_data_d   = dc_data_q;
    ac_valid_d  = 1'b0;
    ac_run_d    = ac_run_q;
    ac_level_d  = ac_level_q;
    blk_done_d  = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.blk_valid) begin
          load        = 1'b1;
          ss_d        = bus.slice_start;
`ifdef PRORES_INTERLACED_SCAN_EN
          sel_d       = bus.scan_sel;
`endif
          blk_ready_d = 1'b0;
          state_d     = S_DC;
        end
      end
      S_DC: begin
        dc_valid_d = 1'b1;
        dc_data_d  = ss_q ? coef_q[0][0] : coef_q[0][0] - prev_dc_q;
        prev_dc_d  = coef_q[0][0];
        idx_d      = IDX_W'(1);
        run_d      = '0;
        state_d    = S_AC;
      end
      S_AC: begin
        if (scan_coef != '0) begin
          ac_valid_d = 1'b1;
          ac_run_d   = run_q;
          ac_level_d = scan_coef;
          run_d      = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          blk_done_d  = 1'b1;
          blk_ready_d = 1'b1;
          idx_d       = '0;
          run_d       = '0;
          state_d     = S_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        blk_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      run_q       <= '0;
      prev_dc_q   <= '0;
      ss_q        <= 1'b0;
`ifdef PRORES_INTERLACED_SCAN_EN
      sel_q       <= 1'b0;
`endif
      blk_ready_q <= 1'b1;
      dc_valid_q  <= 1'b0;
      dc_data_q   <= '0;
      ac_valid_q  <= 1'b0;
      ac_run_q    <= '0;
      ac_level_q  <= '0;
      blk_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      prev_dc_q   <= prev_dc_d;
      ss_q        <= ss_d;
`ifdef PRORES_INTERLACED_SCAN_EN
      sel_q       <= sel_d;
`endif
      blk_ready_q <= blk_ready_d;
      dc_valid_q  <= dc_valid_d;
      dc_data_q   <= dc_data_d;
      ac_valid_q  <= ac_valid_d;
      ac_run_q    <= ac_run_d;
      ac_level_q  <= ac_level_d;
      blk_done_q  <= blk_done_d;
    end
  end

  // Capture the clamped block on acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          coef_q[r][c] <= '0;
    end else if (load) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          coef_q[r][c] <= clamp_coef(bus.BLK_DATA[r][c]);
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.dc_valid  = dc_valid_q;
  assign bus.DC_DATA   = dc_data_q;
  assign bus.ac_valid  = ac_valid_q;
  assign bus.AC_RUN    = ac_run_q;
  assign bus.AC_LEVEL  = ac_level_q;
  assign bus.blk_done  = blk_done_q;

endmodule

// File: tb/tb_prores_block_scan_ctrl.sv
// Self-checking bench for prores_block_scan_ctrl: a per-cycle expectation
// timeline is built from each accepted block and compared every cycle.
// Honours PRORES_INTERLACED_SCAN_EN when the design is built with it.
module tb_prores_block_scan_ctrl;
  localparam int MAXC = 8192;
  localparam int HI   = 262143;
  localparam int LO   = -262144;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  prores_block_scan_ctrl_if bus ();
  prores_block_scan_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int prog_scan [64] = '{
     0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
     4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int ilace_scan [64] = '{
     0,  8,  1,  9, 16, 24, 17, 25,  2, 10,  3, 11, 18, 26, 19, 27,
    32, 40, 33, 34, 41, 48, 56, 49, 42, 35, 43, 50, 57, 58, 51, 59,
     4, 12,  5,  6, 13, 20, 28, 21, 14,  7, 15, 22, 29, 36, 44, 37,
    30, 23, 31, 38, 45, 52, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63};

  // Expected timeline, indexed by the clock edge after which it is observed
  bit e_dcv  [MAXC];
  int e_dcd  [MAXC];
  bit e_acv  [MAXC];
  int e_run  [MAXC];
  int e_lvl  [MAXC];
  bit e_done [MAXC];
  bit e_busy [MAXC];

  int prev_dc   = 0;
  int next_free = 0;
  int blk [8][8];
  bit cur_ss  = 1'b0;
  bit cur_sel = 1'b0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, k, act, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > HI) ? HI : ((v < LO) ? LO : v);
  endfunction

  // Record everything a block accepted at edge t must produce
  task automatic model_accept(input int t, input bit ss, input bit sel);
    int cl [64];
    int run;
    int v;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        cl[r*8+c] = clampv(blk[r][c]);
    e_dcv[t+1] = 1'b1;
    e_dcd[t+1] = ss ? cl[0] : cl[0] - prev_dc;
    prev_dc = cl[0];
    run = 0;
    for (int i = 1; i < 64; i++) begin
      v = cl[sel ? ilace_scan[i] : prog_scan[i]];
      if (v != 0) begin
        e_acv[t+1+i] = 1'b1;
        e_run[t+1+i] = run;
        e_lvl[t+1+i] = v;
        run = 0;
      end else begin
        run++;
      end
    end
    e_done[t+64] = 1'b1;
    for (int k = t; k < t + 64; k++) e_busy[k] = 1'b1;
    next_free = t + 65;
  endtask

  // Drive the current block at a falling edge; t = accepting edge or -1
  task automatic present(input bit valid, output int t);
    bus.blk_valid   = valid;
    bus.slice_start = cur_ss;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bus.BLK_DATA[r][c] = blk[r][c];
`ifdef PRORES_INTERLACED_SCAN_EN
    bus.scan_sel = cur_sel;
`endif
    t = -1;
    if (valid && reset_n && (cyc + 1) >= next_free) begin
      t = cyc + 1;
      model_accept(t, cur_ss, cur_sel);
    end
  endtask

  task automatic clear_blk();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        blk[r][c] = 0;
  endtask

  task automatic send(input bit ss, output int t);
    while (cyc + 1 < next_free) @(negedge clk);
    cur_ss = ss;
    present(1'b1, t);
    @(negedge clk);
    bus.blk_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    int n;
    bus.blk_valid = 1'b0;
    reset_n = 1'b0;
    n = cyc;
    for (int k = n + 1; k < n + 80 && k < MAXC; k++) begin
      e_dcv[k] = 1'b0; e_acv[k] = 1'b0; e_done[k] = 1'b0; e_busy[k] = 1'b0;
    end
    prev_dc = 0;
    next_free = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rand_blk();
    bit sparse;
    sparse = ($urandom_range(0, 4) == 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        case ($urandom_range(0, 7))
          0:       blk[r][c] = int'($urandom);
          1, 2:    blk[r][c] = int'($urandom_range(0, 63)) - 32;
          default: blk[r][c] = 0;
        endcase
        if (sparse && (r != 0 || c != 0)) blk[r][c] = 0;
      end
  endtask

  // Every-cycle comparison against the expected timeline
  initial begin
    int k, hd, hr, hl;
    hd = 0; hr = 0; hl = 0;
    forever begin
      @(posedge clk);
      #1;
      k = cyc;
      if (k < MAXC) begin
        if (!reset_n) begin hd = 0; hr = 0; hl = 0; end
        if (e_dcv[k]) hd = e_dcd[k];
        if (e_acv[k]) begin hr = e_run[k]; hl = e_lvl[k]; end
        chk("blk_ready", k, int'(bus.blk_ready), int'(!e_busy[k]));
        chk("dc_valid",  k, int'(bus.dc_valid),  int'(e_dcv[k]));
        chk("ac_valid",  k, int'(bus.ac_valid),  int'(e_acv[k]));
        chk("blk_done",  k, int'(bus.blk_done),  int'(e_done[k]));
        chk("DC_DATA",   k, int'($signed(bus.DC_DATA)),  hd);
        chk("AC_RUN",    k, int'(bus.AC_RUN),            hr);
        chk("AC_LEVEL",  k, int'($signed(bus.AC_LEVEL)), hl);
      end
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int dummy;
    reset_n = 1'b1;
    bus.blk_valid = 1'b0;
    bus.slice_start = 1'b0;
    bus.BLK_DATA = '0;
`ifdef PRORES_INTERLACED_SCAN_EN
    bus.scan_sel = 1'b0;
`endif
    clear_blk();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    repeat (100) @(negedge clk);
    chk("idle_ready", cyc, int'(bus.blk_ready), 1);
    chk("idle_dcv",   cyc, int'(bus.dc_valid),  0);

    // DC only, new slice
    clear_blk(); blk[0][0] = 100;
    send(1'b1, t);
    wait_cyc(t + 1);
    chk("a_dc_valid", cyc, int'(bus.dc_valid), 1);
    chk("a_dc_data",  cyc, int'($signed(bus.DC_DATA)), 100);
    wait_cyc(t + 64);
    chk("a_done",     cyc, int'(bus.blk_done), 1);
    chk("a_no_ac",    cyc, int'(bus.ac_valid), 0);

    // Predicted DC with two AC levels
    clear_blk(); blk[0][0] = 90; blk[0][1] = 5; blk[0][2] = -3;
    send(1'b0, t);
    wait_cyc(t + 1);
    chk("b_dc_data",  cyc, int'($signed(bus.DC_DATA)), -10);
    wait_cyc(t + 2);
    chk("b_ac1_v",    cyc, int'(bus.ac_valid), 1);
    chk("b_ac1_run",  cyc, int'(bus.AC_RUN), 0);
    chk("b_ac1_lvl",  cyc, int'($signed(bus.AC_LEVEL)), 5);
    wait_cyc(t + 5);
    chk("b_ac2_v",    cyc, int'(bus.ac_valid), 1);
    chk("b_ac2_run",  cyc, int'(bus.AC_RUN), 2);
    chk("b_ac2_lvl",  cyc, int'($signed(bus.AC_LEVEL)), -3);
    wait_cyc(t + 64);
    chk("b_done",     cyc, int'(bus.blk_done), 1);

    // Clamping at both extremes
    clear_blk(); blk[0][0] = 32'h7FFF_FFFF;
    send(1'b1, t);
    wait_cyc(t + 1);
    chk("c_dc_hi",    cyc, int'($signed(bus.DC_DATA)), 262143);
    clear_blk(); blk[0][0] = 32'h8000_0000;
    send(1'b0, t);
    wait_cyc(t + 1);
    chk("c_dc_lo",    cyc, int'($signed(bus.DC_DATA)), -524287);

    // Only the last scan position nonzero: run 62 coincident with done
    clear_blk(); blk[7][7] = 1;
    send(1'b1, t);
    wait_cyc(t + 64);
    chk("d_ac_v",     cyc, int'(bus.ac_valid), 1);
    chk("d_run",      cyc, int'(bus.AC_RUN), 62);
    chk("d_lvl",      cyc, int'($signed(bus.AC_LEVEL)), 1);
    chk("d_done",     cyc, int'(bus.blk_done), 1);

    // Abort mid-scan, predictor restarts from zero
    clear_blk(); blk[0][0] = 55; blk[3][3] = 9;
    send(1'b1, t);
    wait_cyc(t + 29);
    do_reset();
    clear_blk(); blk[0][0] = 7;
    send(1'b0, t);
    wait_cyc(t + 1);
    chk("e_dc_data",  cyc, int'($signed(bus.DC_DATA)), 7);
    wait_cyc(t + 64);

    // Randomized traffic, including offers while busy and one reset
    for (int i = 0; i < 2600; i++) begin
      if ($urandom_range(0, 2) == 0) rand_blk();
      cur_ss = 1'($urandom_range(0, 1));
`ifdef PRORES_INTERLACED_SCAN_EN
      cur_sel = 1'($urandom_range(0, 1));
`endif
      present($urandom_range(0, 3) != 0, dummy);
      @(negedge clk);
      if (i == 1300) do_reset();
    end
    bus.blk_valid = 1'b0;
    repeat (70) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prores_block_scan_ctrl.md
Name: prores_block_scan_ctrl

Overview:
- Sequences one quantized 8x8 block at a time from the quantizer output into the entropy coders.
- Latches the 64 coefficients, emits a predicted DC value, then scans the 63 AC positions in ProRes progressive scan order.
- Emits (run, level) pairs for nonzero AC coefficients and signals end of block.
- Sits between pre_quant_qt_qscale and the entropy_encode_dc/ac_level/ac_run coefficient encoders.

Parameters:
- IN_W, 32, width of each input coefficient word (two's complement).
- COEF_W, 20, width of DC/level outputs (19-bit magnitude range plus 1 guard bit).
- RUN_W, 6, width of zero-run output (0..62).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- slice_start  in  1  qualified by blk_valid&blk_ready; marks the first block of a slice (DC predictor reset).
- blk_valid  in  1  block coefficients valid.
- blk_ready  out  1  controller can accept a block.
- BLK_DATA  in  IN_W x [8][8]  quantized coefficients, [row][col].
- dc_valid  out  1  one-cycle strobe, DC_DATA valid.
- DC_DATA  out  COEF_W  DC value or DC delta, two's complement.
- ac_valid  out  1  one-cycle strobe, AC_RUN/AC_LEVEL valid.
- AC_RUN  out  RUN_W  zeros preceding this level in scan order.
- AC_LEVEL  out  COEF_W  nonzero level, two's complement.
- blk_done  out  1  one-cycle strobe, block fully scanned.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, blk_ready=1.
  - dc_valid, ac_valid, blk_done = 0.
  - DC_DATA, AC_RUN, AC_LEVEL = 0.
  - prev_dc=0, run counter=0, scan index=0.
- States: IDLE -> DC -> AC -> IDLE.
- IDLE:
  - blk_ready=1.
  - On blk_valid=1 at edge T: latch all 64 coefficients and slice_start; go to DC.
  - Each coefficient is clamped to [-262144, 262143] (19-bit signed) and sign-extended to COEF_W.
- DC (cycle T+1):
  - blk_ready=0, dc_valid=1.
  - DC_DATA = clamp(BLK[0][0]) if latched slice_start=1, else clamp(BLK[0][0]) - prev_dc.
  - The subtraction is computed in COEF_W bits; it cannot overflow because of the clamp.
  - prev_dc <= clamp(BLK[0][0]).
  - Go to AC with scan index=1, run=0.
- AC (cycles T+2..T+64, one scan position per cycle):
  - Index i visits position scan[i] of the ProRes progressive scan table.
  - Zero coefficient: run<=run+1, ac_valid=0.
  - Nonzero coefficient: ac_valid=1, AC_RUN=run, AC_LEVEL=coef, run<=0.
  - At i=63: blk_done=1 in the same cycle, then go to IDLE (blk_ready=1 at T+65).
  - Trailing zeros after the last nonzero are never emitted.
- Outputs are registered; data ports hold their last value when the corresponding strobe is low.
- Throughput: one block per 65 cycles. blk_valid during DC/AC is ignored (not accepted).
- Boundary cases:
  - All-zero AC block: dc_valid only, then blk_done at T+64 with no ac_valid.
  - Scan position 63 nonzero: ac_valid and blk_done in the same cycle.
  - Max run = 62: first nonzero at scan index 63, or all AC zero except the last.
  - reset_n asserted mid-block: abort immediately, no blk_done, prev_dc=0.
  - slice_start=1 on a non-accepted cycle has no effect.

Optional Feature:
- Macro PRORES_INTERLACED_SCAN_EN.
- Defined: adds input port scan_sel (1 bit, sampled with the block). scan_sel=1 uses the ProRes interlaced scan table for the AC scan; scan_sel=0 uses the progressive table.
- Undefined: no scan_sel port; progressive table only; logic for the second table is absent.

Test Plan:
- Reset then idle: blk_ready=1; dc_valid, ac_valid, blk_done stay 0 for 100 cycles.
- Single block, slice_start=1, DC=100, all AC zero: dc_valid at T+1 with DC_DATA=100; blk_done at T+64; no ac_valid.
- Second block, slice_start=0, DC=90, scan[1]=5, scan[4]=-3, rest zero: DC_DATA=-10; (run0, level5) at T+2; (run2, level-3) at T+5; blk_done at T+64.
- Clamping: DC=0x7FFFFFFF then next DC=-0x80000000, slice_start=0: first DC_DATA=262143; second DC_DATA=-524287.
- Last-position and max run: only scan[63]=1 nonzero: single ac_valid with AC_RUN=62, AC_LEVEL=1, coincident with blk_done.
- Reset mid-scan at T+30, then a new block with slice_start=0 and DC=7: no blk_done for the aborted block; DC_DATA=7 (prev_dc cleared).
